cic_sequencer: RTL and testbench

CIC_SEQUENCER -- requirements
Module: cic_sequencer

---
 rtl/cic_sequencer.sv | 124 ++++++++++++
 tb/tb_cic_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_sequencer.sv
// cic_sequencer: PDM clock generation, CIC integrator/differentiator enables,
// start-up settling and frame capture with a single-entry output handshake.
module cic_sequencer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned DEC_RATIO = 64,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned CH        = 16,
    parameter int unsigned W         = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            pdm_clk_o,
    output logic            sample_en,
    output logic            dec_en,
    input  logic [CH*W-1:0] cic_data,
    output logic [CH*W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun,
    output logic            busy
);

    localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW   = (DEC_RATIO > 1) ? $clog2(DEC_RATIO) : 1;
    localparam int unsigned TW   = $clog2(SETTLE + 2);
    localparam int unsigned HALF = CLK_DIV / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t        state;
    logic [DW-1:0] dcnt;
    logic [SW-1:0] scnt;
    logic [TW-1:0] settle_cnt;

    logic [DW-1:0] dcnt_n;
    logic [SW-1:0] scnt_n;
    logic          sample_n;
    logic          dec_n;
    logic          pdm_n;

    // Next divider/sample counts; strobes are decoded from them so the
    // registered outputs line up with the counter values of the same cycle.
    always_comb begin
        dcnt_n = '0;
        scnt_n = '0;
        if (en && state != ST_IDLE) begin
            dcnt_n = (dcnt == DW'(CLK_DIV - 1)) ? '0 : dcnt + DW'(1);
            scnt_n = scnt;
            if (sample_en) begin
                scnt_n = (scnt == SW'(DEC_RATIO - 1)) ? '0 : scnt + SW'(1);
            end
        end
        sample_n = en && (dcnt_n == DW'(CLK_DIV - 1));
        dec_n    = sample_n && (scnt_n == SW'(DEC_RATIO - 1));
        pdm_n    = en && (dcnt_n >= DW'(HALF));
    end

    // Sequencer state, counters, registered strobes and output frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            dcnt       <= '0;
            scnt       <= '0;
            settle_cnt <= '0;
            pdm_clk_o  <= 1'b0;
            sample_en  <= 1'b0;
            dec_en     <= 1'b0;
            busy       <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dcnt      <= dcnt_n;
            scnt      <= scnt_n;
            pdm_clk_o <= pdm_n;
            sample_en <= sample_n;
            dec_en    <= dec_n;
            busy      <= en;
            if (!en) begin
                // Stopping drops any capture pending on this edge.
                state      <= ST_IDLE;
                settle_cnt <= '0;
                out_valid  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                        settle_cnt <= '0;
                        overrun    <= 1'b0;
                    end
                    ST_SETTLE: begin
                        if (dec_en) begin
                            if (settle_cnt == TW'(SETTLE - 1)) begin
                                state      <= ST_RUN;
                                settle_cnt <= '0;
                            end else begin
                                settle_cnt <= settle_cnt + TW'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (dec_en) begin
                            // A new frame always wins over a same-edge accept.
                            out_data  <= cic_data;
                            out_valid <= 1'b1;
                            if (out_valid && !out_ready) begin
                                overrun <= 1'b1;
                            end
                        end else if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cic_sequencer.sv
// Testbench for cic_sequencer: directed scenarios plus a randomized run
// checked against a cycle-count based reference model.
module tb_cic_sequencer;

    localparam int unsigned CD   = 4;
    localparam int unsigned DR   = 8;
    localparam int unsigned ST   = 2;
    localparam int unsigned CH   = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned P    = CD * DR;
    localparam int unsigned DWID = CH * W;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            out_ready;
    logic [DWID-1:0] cic_data;
    logic [DWID-1:0] out_data;
    logic            pdm_clk_o;
    logic            sample_en;
    logic            dec_en;
    logic            out_valid;
    logic            overrun;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: cycles since start decide every strobe.
    bit              m_active;
    int unsigned     m_k;
    bit              m_valid;
    bit              m_ovr;
    logic [DWID-1:0] m_data;

    cic_sequencer #(
        .CLK_DIV  (CD),
        .DEC_RATIO(DR),
        .SETTLE   (ST),
        .CH       (CH),
        .W        (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pdm_clk_o(pdm_clk_o),
        .sample_en(sample_en),
        .dec_en   (dec_en),
        .cic_data (cic_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Expected {busy, pdm_clk_o, sample_en, dec_en} for the current cycle.
    function automatic logic [3:0] exp_ctrl();
        logic [3:0] e;
        e[3] = m_active;
        e[2] = m_active && ((m_k % CD) >= CD / 2);
        e[1] = m_active && ((m_k % CD) == CD - 1);
        e[0] = m_active && ((m_k % P) == P - 1);
        return e;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_data   = '0;
    endtask

    // Advance model with the current inputs, then one clock edge.
    task automatic step();
        bit cap;
        if (!en) begin
            m_active = 1'b0;
            m_k      = 0;
            m_valid  = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_k      = 0;
            m_ovr    = 1'b0;
        end else begin
            cap = ((m_k % P) == P - 1) && (((m_k + 1) / P) > ST);
            if (cap) begin
                if (m_valid && !out_ready) m_ovr = 1'b1;
                m_data  = cic_data;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            m_k++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        en = 1'b0; out_ready = 1'b0; cic_data = '0; rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if ({pdm_clk_o, sample_en, dec_en, out_valid, overrun, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {pdm_clk_o, sample_en, dec_en, out_valid, overrun, busy});
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_timing();
        int last;
        last = -1;
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cic_data = DWID'($urandom);
            step();
            n_cmp++;
            if ({busy, pdm_clk_o, sample_en, dec_en} !== exp_ctrl()) begin
                n_bad++;
                $display("FAIL timing_ctrl: got %b want %b at cycle %0d",
                         {busy, pdm_clk_o, sample_en, dec_en}, exp_ctrl(), cyc);
            end
            if (dec_en) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != int'(P)) begin
                        n_bad++;
                        $display("FAIL dec_period: got %0d want %0d", cyc - last, P);
                    end
                end
                last = cyc;
            end
        end
    endtask

    task automatic test_settle_capture();
        int nd;
        bit done;
        logic [DWID-1:0] cd;
        cd = '0;
        en = 1'b0;
        step(); step();
        n_cmp++;
        if ({busy, pdm_clk_o, out_valid} !== 3'b0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %b want 000", {busy, pdm_clk_o, out_valid});
        end
        en = 1'b1; out_ready = 1'b0; nd = 0; done = 1'b0;
        for (int i = 0; i < int'(4 * P) && !done; i++) begin
            cic_data = DWID'($urandom);
            if (dec_en) begin
                nd++;
                cd = cic_data;
            end
            step();
            if (nd == ST + 1) begin
                done = 1'b1;
                n_cmp++;
                if ({out_valid, out_data} !== {1'b1, cd}) begin
                    n_bad++;
                    $display("FAIL first_frame: got v=%b d=%h want v=1 d=%h", out_valid, out_data, cd);
                end
            end else begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL settle_no_valid: got %b want 0 after %0d dec_en", out_valid, nd);
                end
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL settle_timeout: got %0d dec_en want %0d", nd, ST + 1);
        end
    endtask

    task automatic test_overrun();
        int caps;
        logic [DWID-1:0] cd;
        cd = '0; caps = 0; out_ready = 1'b0;
        for (int i = 0; i < int'(4 * P) && caps < 2; i++) begin
            cic_data = DWID'($urandom);
            if (dec_en) begin
                caps++;
                cd = cic_data;
            end
            step();
        end
        n_cmp++;
        if (caps != 2) begin
            n_bad++;
            $display("FAIL overrun_wait: got %0d captures want 2", caps);
        end
        n_cmp++;
        if ({out_valid, overrun, out_data} !== {1'b1, 1'b1, cd}) begin
            n_bad++;
            $display("FAIL overrun_frame: got v=%b o=%b d=%h want v=1 o=1 d=%h",
                     out_valid, overrun, out_data, cd);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if ({out_valid, overrun} !== 2'b01) begin
            n_bad++;
            $display("FAIL overrun_sticky: got %b want 01", {out_valid, overrun});
        end
        en = 1'b0;
        step();
        n_cmp++;
        if ({busy, overrun} !== 2'b01) begin
            n_bad++;
            $display("FAIL overrun_idle: got %b want 01", {busy, overrun});
        end
        en = 1'b1;
        step();
        n_cmp++;
        if ({busy, overrun} !== 2'b10) begin
            n_bad++;
            $display("FAIL overrun_restart: got %b want 10", {busy, overrun});
        end
    endtask

    task automatic test_ready_on_capture();
        int i;
        logic [DWID-1:0] cd;
        out_ready = 1'b0; i = 0;
        while (!out_valid && i < int'(5 * P)) begin
            cic_data = DWID'($urandom);
            step();
            i++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL roc_wait_valid: got %b want 1", out_valid);
        end
        i = 0;
        while (!dec_en && i < int'(2 * P)) begin
            cic_data = DWID'($urandom);
            step();
            i++;
        end
        n_cmp++;
        if (dec_en !== 1'b1) begin
            n_bad++;
            $display("FAIL roc_wait_dec: got %b want 1", dec_en);
        end
        out_ready = 1'b1;
        cic_data = DWID'($urandom);
        cd = cic_data;
        step();
        n_cmp++;
        if ({out_valid, overrun, out_data} !== {1'b1, 1'b0, cd}) begin
            n_bad++;
            $display("FAIL ready_on_capture: got v=%b o=%b d=%h want v=1 o=0 d=%h",
                     out_valid, overrun, out_data, cd);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL roc_consume: got %b want 0", out_valid);
        end
    endtask

    task automatic test_en_drop();
        int i;
        int nd;
        logic [DWID-1:0] prev;
        i = 0;
        while (!dec_en && i < int'(2 * P)) begin
            cic_data = DWID'($urandom);
            step();
            i++;
        end
        prev = out_data;
        cic_data = ~prev;
        en = 1'b0;
        step();
        n_cmp++;
        if ({busy, pdm_clk_o, sample_en, dec_en, out_valid, out_data} !== {5'b0, prev}) begin
            n_bad++;
            $display("FAIL en_drop: got ctrl=%b d=%h want ctrl=00000 d=%h",
                     {busy, pdm_clk_o, sample_en, dec_en, out_valid}, out_data, prev);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            n_cmp++;
            if ({busy, pdm_clk_o, sample_en} !== 3'b0) begin
                n_bad++;
                $display("FAIL idle_hold: got %b want 000", {busy, pdm_clk_o, sample_en});
            end
        end
        en = 1'b1; out_ready = 1'b1; nd = 0; i = 0;
        while (!out_valid && i < int'(5 * P)) begin
            cic_data = DWID'($urandom);
            if (dec_en) nd++;
            step();
            i++;
        end
        n_cmp++;
        if ({out_valid, nd} !== {1'b1, ST + 1}) begin
            n_bad++;
            $display("FAIL resettle: got v=%b after %0d dec_en want v=1 after %0d", out_valid, nd, ST + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 149) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            cic_data  = DWID'($urandom);
            step();
            n_cmp++;
            if ({busy, pdm_clk_o, sample_en, dec_en} !== exp_ctrl()) begin
                n_bad++;
                $display("FAIL rand_ctrl: got %b want %b at cycle %0d",
                         {busy, pdm_clk_o, sample_en, dec_en}, exp_ctrl(), cyc);
            end
            n_cmp++;
            if ({out_valid, overrun} !== {m_valid, m_ovr}) begin
                n_bad++;
                $display("FAIL rand_flags: got %b want %b at cycle %0d",
                         {out_valid, overrun}, {m_valid, m_ovr}, cyc);
            end
            n_cmp++;
            if (out_data !== m_data) begin
                n_bad++;
                $display("FAIL rand_data: got %h want %h at cycle %0d", out_data, m_data, cyc);
            end
        end
    endtask

    task automatic test_async_reset();
        int i;
        en = 1'b1; out_ready = 1'b0; i = 0;
        while (!out_valid && i < int'(6 * P)) begin
            cic_data = DWID'($urandom);
            step();
            i++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pdm_clk_o, sample_en, dec_en, out_valid, overrun, busy, out_data} !== {6'b0, {DWID{1'b0}}}) begin
            n_bad++;
            $display("FAIL async_reset: got ctrl=%b d=%h want all zero",
                     {pdm_clk_o, sample_en, dec_en, out_valid, overrun, busy}, out_data);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            cic_data = DWID'($urandom);
            step();
            n_cmp++;
            if ({busy, pdm_clk_o, sample_en, dec_en, out_valid} !== {exp_ctrl(), m_valid}) begin
                n_bad++;
                $display("FAIL post_reset: got %b want %b at cycle %0d",
                         {busy, pdm_clk_o, sample_en, dec_en, out_valid}, {exp_ctrl(), m_valid}, cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_settle_capture();
        test_overrun();
        test_ready_on_capture();
        test_en_drop();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
